// File: rtl/act_pkg.sv
// Shared mode/state encodings and lane helper for the streaming
// activation/pooling unit.
package act_pkg;

  localparam logic [1:0] MODE_PASS      = 2'b00;
  localparam logic [1:0] MODE_RELU      = 2'b01;
  localparam logic [1:0] MODE_POOL      = 2'b10;
  localparam logic [1:0] MODE_POOL_RELU = 2'b11;

  localparam int ACT_WMAX = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } act_state_e;

  // Operates on a sign-extended sample; callers truncate back.
  function automatic logic signed [ACT_WMAX-1:0] relu_lane(
    input logic signed [ACT_WMAX-1:0] x
  );
    return x[ACT_WMAX-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane: signed running max and ReLU (ReLU-N clamp when
// ACT_CLIP_EN is defined).
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] m_i,
  input  logic              beat_i,
  input  logic              first_i,
  input  logic              relu_i,
`ifdef ACT_CLIP_EN
  input  logic [DATA_W-1:0] clip_i,
`endif
  output logic [DATA_W-1:0] mx_o,
  output logic [DATA_W-1:0] res_o
);

  logic signed [ACT_WMAX-1:0] rl;
  logic [DATA_W-1:0]          rv;
  logic [DATA_W-1:0]          rc;

  always_comb begin
    mx_o = m_i;
    if (beat_i) begin
      if (first_i) begin
        mx_o = x_i;
      end else if ($signed(x_i) > $signed(m_i)) begin
        mx_o = x_i;
      end
    end
  end

  assign rl = relu_lane(ACT_WMAX'($signed(mx_o)));
  assign rv = rl[DATA_W-1:0];

`ifdef ACT_CLIP_EN
  // rv is non-negative here, so an unsigned compare is correct.
  assign rc = (rv > clip_i) ? clip_i : rv;
`else
  assign rc = rv;
`endif

  assign res_o = relu_i ? rc : mx_o;

endmodule

// File: rtl/act_pool_stream.sv
// Streaming ReLU / max-pool stage with valid/ready and flush.
// Optional ReLU-N clamp via ACT_CLIP_EN.
module act_pool_stream
  import act_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int POOL_MAX = 4,
  localparam int LW      = $clog2(POOL_MAX+1)
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    epol,
  input  logic                    eact,
  input  logic [LW-1:0]           pool_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    flush,
`ifdef ACT_CLIP_EN
  input  logic [DATA_W-1:0]       clip_max,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy
);

  act_state_e state_q, state_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           len_q, len_d;
  logic [1:0]              mode_q, mode_d;
  logic [LANES*DATA_W-1:0] max_q, max_d;
  logic                    ov_q, ov_d;
  logic [LANES*DATA_W-1:0] od_q, od_d;
  logic                    pend_q, pend_d;
`ifdef ACT_CLIP_EN
  logic [DATA_W-1:0]       clip_q, clip_d, clip_e;
`endif

  logic                    idle, acc, fl, emit, last;
  logic [1:0]              mode_e;
  logic [LW-1:0]           len_new, len_e;
  logic [LANES*DATA_W-1:0] mx, res;

  assign idle     = (state_q == S_IDLE);
  assign in_ready = !rst && (!ov_q || out_ready);
  assign acc      = in_valid && in_ready;
  assign fl       = flush || pend_q;
  assign mode_e   = idle ? {epol, eact} : mode_q;
`ifdef ACT_CLIP_EN
  assign clip_e   = idle ? clip_max : clip_q;
`endif

  always_comb begin
    len_new = LW'(1);
    if (epol) begin
      if (pool_len > LW'(POOL_MAX)) begin
        len_new = LW'(POOL_MAX);
      end else if (pool_len != '0) begin
        len_new = pool_len;
      end
    end
  end

  assign len_e = idle ? len_new : len_q;
  assign last  = (cnt_q + LW'(1)) == len_e;

  // Flush without a beat drains only a held partial window.
  assign emit = acc ? (last || fl)
                    : (!idle && fl && in_ready);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(.DATA_W(DATA_W)) u_lane (
      .x_i    (in_data[g*DATA_W +: DATA_W]),
      .m_i    (max_q[g*DATA_W +: DATA_W]),
      .beat_i (acc),
      .first_i(idle),
      .relu_i (mode_e[0]),
`ifdef ACT_CLIP_EN
      .clip_i (clip_e),
`endif
      .mx_o   (mx[g*DATA_W +: DATA_W]),
      .res_o  (res[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    max_d   = max_q;
    ov_d    = ov_q;
    od_d    = od_q;
    pend_d  = 1'b0;
`ifdef ACT_CLIP_EN
    clip_d  = clip_q;
`endif
    if (acc) begin
      max_d = mx;
      if (idle) begin
        mode_d = mode_e;
        len_d  = len_e;
`ifdef ACT_CLIP_EN
        clip_d = clip_e;
`endif
      end
    end
    if (emit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (acc) begin
      state_d = S_ACC;
      cnt_d   = cnt_q + LW'(1);
    end
    if (!idle && fl && !emit) begin
      pend_d = 1'b1;
    end
    if (emit) begin
      ov_d = 1'b1;
      od_d = res;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= LW'(1);
      mode_q  <= MODE_PASS;
      max_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      pend_q  <= 1'b0;
`ifdef ACT_CLIP_EN
      clip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      max_q   <= max_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      pend_q  <= pend_d;
`ifdef ACT_CLIP_EN
      clip_q  <= clip_d;
`endif
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_act_pool_stream.sv
// Directed bench for act_pool_stream; covers the clip path when
// ACT_CLIP_EN is defined.
module tb_act_pool_stream;

  logic        CLK = 1'b0;
  logic        rst;
  logic        epol, eact;
  logic [2:0]  pool_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef ACT_CLIP_EN
  logic [7:0]  clip_max;
`endif

  int errs = 0;
  int chks = 0;

  always #5 CLK = ~CLK;

  act_pool_stream dut (
    .CLK      (CLK),
    .rst      (rst),
    .epol     (epol),
    .eact     (eact),
    .pool_len (pool_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
`ifdef ACT_CLIP_EN
    .clip_max (clip_max),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mode(input logic p, input logic a,
                      input logic [2:0] l);
    epol = p;
    eact = a;
    pool_len = l;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mode(1'b0, 1'b0, 3'd1);
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
`ifdef ACT_CLIP_EN
    clip_max = 8'd127;
`endif
    cyc();
    cyc();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_od", out_data, 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    // ReLU at full throughput
    mode(1'b0, 1'b1, 3'd0);
    in_valid = 1'b1;
    in_data = 32'h800700FB;
    cyc();
    chk("relu1_ov", 32'(out_valid), 32'd1);
    chk("relu1_od", out_data, 32'h00070000);
    chk("relu1_rdy", 32'(in_ready), 32'd1);
    in_data = 32'h05FF03FE;
    cyc();
    chk("relu2_ov", 32'(out_valid), 32'd1);
    chk("relu2_od", out_data, 32'h05000300);
    in_valid = 1'b0;
    cyc();
    chk("relu_drain", 32'(out_valid), 32'd0);

    // Max-pool window of 3
    mode(1'b1, 1'b0, 3'd3);
    beat(32'h00000003);
    chk("p3_busy1", 32'(busy), 32'd1);
    chk("p3_ov1", 32'(out_valid), 32'd0);
    mode(1'b0, 1'b1, 3'd1);
    beat(32'h000000F7);
    chk("p3_busy2", 32'(busy), 32'd1);
    chk("p3_ov2", 32'(out_valid), 32'd0);
    beat(32'h0000000C);
    chk("p3_ov3", 32'(out_valid), 32'd1);
    chk("p3_od", out_data, 32'h0000000C);
    chk("p3_busy3", 32'(busy), 32'd0);
    cyc();

    // Pool then ReLU vs pool only
    mode(1'b1, 1'b1, 3'd2);
    beat(32'h000000FC);
    beat(32'h000000FE);
    chk("pr_ov", 32'(out_valid), 32'd1);
    chk("pr_od", out_data, 32'h00000000);
    mode(1'b1, 1'b0, 3'd2);
    beat(32'h000000FC);
    beat(32'h000000FE);
    chk("pp_ov", 32'(out_valid), 32'd1);
    chk("pp_od", out_data, 32'h000000FE);
    cyc();

    // pool_len 0 -> 1, pool_len 7 -> POOL_MAX
    mode(1'b1, 1'b0, 3'd0);
    beat(32'h000000FD);
    chk("len0_ov", 32'(out_valid), 32'd1);
    chk("len0_od", out_data, 32'h000000FD);
    mode(1'b1, 1'b0, 3'd7);
    beat(32'h00000001);
    beat(32'h00000002);
    beat(32'h00000003);
    chk("len7_busy", 32'(busy), 32'd1);
    chk("len7_ov3", 32'(out_valid), 32'd0);
    beat(32'h00000004);
    chk("len7_ov4", 32'(out_valid), 32'd1);
    chk("len7_od", out_data, 32'h00000004);
    cyc();

    // Flush alone, then flush with a beat
    mode(1'b1, 1'b0, 3'd4);
    beat(32'h00000005);
    beat(32'h00000009);
    chk("fl_ov0", 32'(out_valid), 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_ov", 32'(out_valid), 32'd1);
    chk("fl_od", out_data, 32'h00000009);
    chk("fl_busy", 32'(busy), 32'd0);
    beat(32'h00000005);
    beat(32'h00000009);
    flush = 1'b1;
    beat(32'h0000000B);
    flush = 1'b0;
    chk("flb_ov", 32'(out_valid), 32'd1);
    chk("flb_od", out_data, 32'h0000000B);
    cyc();
    chk("flb_drain", 32'(out_valid), 32'd0);

    // Backpressure
    mode(1'b0, 1'b0, 3'd1);
    out_ready = 1'b0;
    beat(32'h11223344);
    chk("bp_ov", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data = 32'h55667788;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_od", out_data, 32'h11223344);
      chk("bp_ov_hold", 32'(out_valid), 32'd1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_next_od", out_data, 32'h55667788);
    chk("bp_next_ov", 32'(out_valid), 32'd1);
    cyc();

    // Reset mid-window
    mode(1'b1, 1'b0, 3'd3);
    beat(32'h00000001);
    beat(32'h00000002);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_ov", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    beat(32'h00000004);
    beat(32'h00000006);
    chk("mr_ov2", 32'(out_valid), 32'd0);
    beat(32'h00000005);
    chk("mr_ov3", 32'(out_valid), 32'd1);
    chk("mr_od", out_data, 32'h00000006);
    cyc();

`ifdef ACT_CLIP_EN
    clip_max = 8'd6;
    mode(1'b0, 1'b1, 3'd1);
    beat(32'h00000009);
    chk("clip_ov", 32'(out_valid), 32'd1);
    chk("clip_od", out_data, 32'h00000006);
    cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
